// File: rtl/i2s_rx_frontend.sv
// i2s_rx_frontend
//
// Receives I2S serial audio from an external ADC. Only one channel slot is kept.
// Each captured word becomes one signed Q4.12 sample for the DSP chain.
// All logic runs on clk. The I2S lines are asynchronous and pass through
// 2-FF synchronisers. Capture logic advances only on a detected BCLK rise
// (a "bit tick").
//
// Parameters:
//   ADC_WIDTH  data bits captured per slot, MSB first, two's complement
//   FXP_SIZE   output sample width
//   FXP_FRAC   output fractional bits
//   CHANNEL    captured slot: 0 = left (LRCK low), 1 = right (LRCK high)
//
// Ports:
//   clk          system clock, at least 4x the BCLK frequency
//   rst          synchronous active-high reset
//   i2s_bclk     I2S bit clock (asynchronous)
//   i2s_lrck     I2S word select (asynchronous)
//   i2s_sdata    I2S serial data (asynchronous)
//   o_valid      one-cycle pulse: new sample on o_sample
//   o_sample     signed Q4.12 sample, held between pulses
//   o_frame_err  one-cycle pulse: selected slot ended before ADC_WIDTH bits
//
// Build option:
//   I2S_RX_ROUND_EN  when defined, conversion rounds half-up.
//                    When undefined, conversion truncates toward -inf.

module i2s_rx_frontend #(
  parameter int ADC_WIDTH = 24,
  parameter int FXP_SIZE  = 16,
  parameter int FXP_FRAC  = 12,
  parameter int CHANNEL   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i2s_bclk,
  input  logic                i2s_lrck,
  input  logic                i2s_sdata,
  output logic                o_valid,
  output logic [FXP_SIZE-1:0] o_sample,
  output logic                o_frame_err
);

  // Right shift that moves the Q0.(ADC_WIDTH-1) word onto the Q.FXP_FRAC grid
  localparam int SHIFT = ADC_WIDTH - 1 - FXP_FRAC;
  localparam int CNT_W = $clog2(ADC_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADC_WIDTH - 1);
  localparam logic CH_LVL = (CHANNEL != 0);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT_IN  = 2'd1,
    IGNORE    = 2'd2
  } state_t;

  // Synchroniser stages and edge-detect history
  logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic lrck_meta_q, lrck_sync_q;
  logic sdata_meta_q, sdata_sync_q;
  logic lrck_prev_q, lrck_prev_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADC_WIDTH-1:0]   shift_q, shift_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [FXP_SIZE-1:0]    sample_q, sample_d;

  logic                   tick_s;
  logic                   lrck_edge_s;
  logic                   start_s;
  logic [ADC_WIDTH-1:0]   word_s;
  logic [FXP_SIZE-1:0]    trunc_s;
  logic [FXP_SIZE-1:0]    conv_s;
  logic                   unused_s;

  assign tick_s      = bclk_sync_q & ~bclk_prev_q;
  assign lrck_edge_s = tick_s & (lrck_sync_q != lrck_prev_q);
  // A capture starts only on an edge whose new level is the selected channel
  assign start_s     = lrck_edge_s & (lrck_sync_q == CH_LVL);
  assign lrck_prev_d = tick_s ? lrck_sync_q : lrck_prev_q;

  // The word including the bit arriving on this tick. Converting it directly
  // avoids spending an extra cycle on the final shift.
  assign word_s  = {shift_q[ADC_WIDTH-2:0], sdata_sync_q};

  // Arithmetic shift right: keep the top FXP_FRAC+1 bits, then sign-extend
  assign trunc_s = {{(FXP_SIZE-FXP_FRAC-1){word_s[ADC_WIDTH-1]}},
                    word_s[ADC_WIDTH-1:SHIFT]};

`ifdef I2S_RX_ROUND_EN
  // Half-up rounding: add the first discarded bit. The largest result is
  // 0x1000, so the add cannot wrap.
  assign conv_s = trunc_s + {{(FXP_SIZE-1){1'b0}}, word_s[SHIFT-1]};
`else
  assign conv_s = trunc_s;
`endif

  // The shifted-out MSB and the discarded fraction bits have no consumer
  assign unused_s = ^{shift_q[ADC_WIDTH-1], word_s[SHIFT-1:0]};

  // Next-state and output decode for the slot capture FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      WAIT_SYNC: begin
        if (start_s) begin
          state_d = SHIFT_IN;
          cnt_d   = '0;
        end else begin
          state_d = WAIT_SYNC;
        end
      end
      SHIFT_IN: begin
        if (lrck_edge_s) begin
          // Short slot. Drop the word and resync. This edge does not
          // start a new capture, even if it matches the channel level.
          err_d   = 1'b1;
          state_d = WAIT_SYNC;
          cnt_d   = '0;
        end else if (tick_s) begin
          shift_d = word_s;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            sample_d = conv_s;
            valid_d  = 1'b1;
            state_d  = IGNORE;
          end else begin
            state_d  = SHIFT_IN;
          end
        end else begin
          state_d = SHIFT_IN;
        end
      end
      IGNORE: begin
        if (start_s) begin
          state_d = SHIFT_IN;
          cnt_d   = '0;
        end else begin
          state_d = IGNORE;
        end
      end
      default: begin
        state_d = WAIT_SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchronisers, FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_meta_q  <= 1'b0;
      bclk_sync_q  <= 1'b0;
      bclk_prev_q  <= 1'b0;
      lrck_meta_q  <= 1'b0;
      lrck_sync_q  <= 1'b0;
      sdata_meta_q <= 1'b0;
      sdata_sync_q <= 1'b0;
      lrck_prev_q  <= 1'b0;
      state_q      <= WAIT_SYNC;
      cnt_q        <= '0;
      shift_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      sample_q     <= '0;
    end else begin
      bclk_meta_q  <= i2s_bclk;
      bclk_sync_q  <= bclk_meta_q;
      bclk_prev_q  <= bclk_sync_q;
      lrck_meta_q  <= i2s_lrck;
      lrck_sync_q  <= lrck_meta_q;
      sdata_meta_q <= i2s_sdata;
      sdata_sync_q <= sdata_meta_q;
      lrck_prev_q  <= lrck_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      sample_q     <= sample_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_sample    = sample_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Testbench for i2s_rx_frontend. Two instances (CHANNEL 0 and 1) share one
// I2S stream. Expected samples are pushed per channel when a slot is driven,
// then popped when the matching instance pulses o_valid.
module tb_i2s_rx_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        bclk, lrck, sdata;
  logic        v0, e0, v1, e1;
  logic [15:0] s0, s1;

  always #5 clk = ~clk;

  i2s_rx_frontend #(.CHANNEL(0)) u_dut0 (
    .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_sdata(sdata),
    .o_valid(v0), .o_sample(s0), .o_frame_err(e0)
  );

  i2s_rx_frontend #(.CHANNEL(1)) u_dut1 (
    .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_sdata(sdata),
    .o_valid(v1), .o_sample(s1), .o_frame_err(e1)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          exp_err[2];
  logic        pend_err[2];
  int          seen_err0 = 0;
  int          seen_err1 = 0;
  logic        model_prev;
  logic        pad_bit;
  logic [31:0] exp0_w, exp1_w;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] model_conv(input logic [23:0] w);
    int v;
    v = int'($signed(w));
`ifdef I2S_RX_ROUND_EN
    v = v + 1024;
`endif
    v = v >>> 11;
    return v[15:0];
  endfunction

  task automatic send_bit(input logic l, input logic d);
    bclk  = 1'b0;
    lrck  = l;
    sdata = d;
    #40;
    bclk  = 1'b1;
    #40;
  endtask

  // One slot of nbits BCLKs. Bit 0 carries the previous slot's trailing bit.
  task automatic send_slot(input logic lvl, input logic [23:0] w, input int nbits);
    logic is_edge;
    is_edge    = (lvl != model_prev);
    model_prev = lvl;
    if (is_edge) begin
      if (pend_err[int'(!lvl)]) begin
        exp_err[int'(!lvl)]++;
        pend_err[int'(!lvl)] = 1'b0;
      end
      if (nbits - 1 >= 24) begin
        if (lvl) q1.push_back({16'h0, model_conv(w)});
        else     q0.push_back({16'h0, model_conv(w)});
      end else begin
        pend_err[int'(lvl)] = 1'b1;
      end
    end
    send_bit(lvl, pad_bit);
    for (int i = 1; i < nbits; i++) begin
      send_bit(lvl, (i <= 24) ? w[24-i] : pad_bit);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_prev  = 1'b0;
    pend_err[0] = 1'b0;
    pend_err[1] = 1'b0;
    @(negedge clk);
    check_eq("rst_valid0",  {31'h0, v0}, 32'h0);
    check_eq("rst_err0",    {31'h0, e0}, 32'h0);
    check_eq("rst_sample0", {16'h0, s0}, 32'h0);
    check_eq("rst_sample1", {16'h0, s1}, 32'h0);
    #2;
  endtask

  // Scoreboard: pop on each o_valid and count o_frame_err pulses
  always @(negedge clk) begin
    if (v0) begin
      exp0_w = (q0.size() > 0) ? q0.pop_front() : 32'hDEAD_BEEF;
      check_eq("ch0_sample", {16'h0, s0}, exp0_w);
      check_eq("ch0_valid_err_excl", {31'h0, e0}, 32'h0);
    end
    if (v1) begin
      exp1_w = (q1.size() > 0) ? q1.pop_front() : 32'hDEAD_BEEF;
      check_eq("ch1_sample", {16'h0, s1}, exp1_w);
      check_eq("ch1_valid_err_excl", {31'h0, e1}, 32'h0);
    end
    if (e0) seen_err0++;
    if (e1) seen_err1++;
  end

  initial begin
    rst = 1'b1; bclk = 1'b0; lrck = 1'b0; sdata = 1'b0; pad_bit = 1'b0;
    model_prev = 1'b0;
    exp_err[0] = 0; exp_err[1] = 0;
    pend_err[0] = 1'b0; pend_err[1] = 1'b0;
    do_reset(4);

    // Basic capture and channel selection
    send_slot(1'b1, 24'h000000, 32);
    send_slot(1'b0, 24'h400000, 32);
    send_slot(1'b1, 24'hC00000, 32);
    send_slot(1'b0, 24'h123456, 32);
    send_slot(1'b1, 24'hC00000, 32);
    // Full-scale and -1 LSB corners
    send_slot(1'b0, 24'h800000, 32);
    send_slot(1'b1, 24'h000000, 32);
    send_slot(1'b0, 24'h7FFFFF, 32);
    send_slot(1'b1, 24'h000000, 32);
    send_slot(1'b0, 24'hFFFFFF, 32);
    send_slot(1'b1, 24'h000000, 32);

    // Short left slot: 16 bits, then LRCK toggles
    send_slot(1'b0, 24'h400000, 32);
    send_slot(1'b1, 24'h000000, 32);
    send_slot(1'b0, 24'h7FFFFF, 17);
    send_slot(1'b1, 24'h000000, 32);
    check_eq("short_hold0", {16'h0, s0}, 32'h0000_0800);
    check_eq("short_err0",  seen_err0, exp_err[0]);
    send_slot(1'b0, 24'h200000, 32);
    send_slot(1'b1, 24'h000000, 32);

    // 32-bit slots with all-ones trailing bits
    pad_bit = 1'b1;
    send_slot(1'b0, 24'h400000, 32);
    send_slot(1'b1, 24'h400000, 32);
    pad_bit = 1'b0;

    // Reset 12 bits into a left slot
    send_slot(1'b0, 24'h7FFFFF, 13);
    do_reset(2);
    send_slot(1'b0, 24'h7FFFFF, 19);
    send_slot(1'b1, 24'h654321, 32);
    send_slot(1'b0, 24'h100000, 32);
    send_slot(1'b1, 24'h000000, 8);

    for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    check_eq("q0_drained", q0.size(), 32'h0);
    check_eq("q1_drained", q1.size(), 32'h0);
    check_eq("err_cnt0", seen_err0, exp_err[0]);
    check_eq("err_cnt1", seen_err1, exp_err[1]);
    check_eq("final_sample0", {16'h0, s0}, {16'h0, model_conv(24'h100000)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
